// File: rtl/alu_commit_arbiter.sv
// alu_commit_arbiter
// Round-robin commit scheduler between the ALU bank and the register-file write port.
// It picks one held ALU result per cycle, returns a single-cycle clear to that unit,
// and captures the result into a one-entry writeback register with a valid/ready handshake.
module alu_commit_arbiter #(
    parameter int N_ALU      = 4,
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [N_ALU-1:0]              alu_valid,
    input  logic [N_ALU*XLEN-1:0]         alu_res,
    input  logic [N_ALU*REG_ADDR_W-1:0]   alu_rd,
    input  logic [N_ALU-1:0]              alu_error,
    output logic [N_ALU-1:0]              alu_clear,
    input  logic                          flush,
    output logic                          wb_valid,
    input  logic                          wb_ready,
    output logic [XLEN-1:0]               wb_res,
    output logic [REG_ADDR_W-1:0]         wb_rd,
    output logic                          wb_error,
    output logic [$clog2(N_ALU)-1:0]      wb_src
);

    localparam int PTR_W = $clog2(N_ALU);
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(N_ALU - 1);
    localparam logic [PTR_W:0]   N_WIDE   = (PTR_W + 1)'(N_ALU);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } wb_state_t;

    wb_state_t              state_q, state_d;
    logic [XLEN-1:0]        res_q, res_d;
    logic [REG_ADDR_W-1:0]  rd_q, rd_d;
    logic                   err_q, err_d;
    logic [PTR_W-1:0]       src_q, src_d;
    logic [PTR_W-1:0]       rr_ptr_q, rr_ptr_d;
    // Units cleared last cycle still show valid for one cycle; they must be ignored.
    logic [N_ALU-1:0]       stale_mask_q, stale_mask_d;

    logic [XLEN-1:0]        res_arr [N_ALU];
    logic [REG_ADDR_W-1:0]  rd_arr  [N_ALU];

    logic [N_ALU-1:0]       eligible;
    logic [2*N_ALU-1:0]     elig_dbl;
    logic [N_ALU-1:0]       elig_rot;
    logic                   found;
    logic [PTR_W-1:0]       win_off;
    logic [PTR_W:0]         win_sum;
    logic [PTR_W:0]         win_wrap;
    logic [PTR_W-1:0]       win_idx;
    logic [PTR_W-1:0]       next_ptr;
    logic                   can_accept;
    logic                   win_drop;

    // Unpack the flat per-unit buses into indexable arrays.
    genvar gi;
    generate
        for (gi = 0; gi < N_ALU; gi++) begin : g_unpack
            assign res_arr[gi] = alu_res[gi*XLEN +: XLEN];
            assign rd_arr[gi]  = alu_rd[gi*REG_ADDR_W +: REG_ADDR_W];
        end
    endgenerate

    assign wb_valid   = (state_q == ST_FULL);
    assign wb_res     = res_q;
    assign wb_rd      = rd_q;
    assign wb_error   = err_q;
    assign wb_src     = src_q;
    assign can_accept = !wb_valid || wb_ready;

    // Rotate the eligible vector so bit 0 is the unit at rr_ptr; the lowest set bit wins.
    assign eligible = alu_valid & ~stale_mask_q;
    assign elig_dbl = {eligible, eligible} >> rr_ptr_q;
    assign elig_rot = elig_dbl[N_ALU-1:0];

    // Priority-encode the rotated vector into an offset from rr_ptr.
    always_comb begin
        found   = 1'b0;
        win_off = '0;
        for (int k = N_ALU - 1; k >= 0; k--) begin
            if (elig_rot[k]) begin
                found   = 1'b1;
                win_off = PTR_W'(k);
            end
        end
    end

    // Map the offset back to an absolute unit index and compute the pointer after it.
    always_comb begin
        win_sum  = {1'b0, rr_ptr_q} + {1'b0, win_off};
        win_wrap = (win_sum >= N_WIDE) ? (win_sum - N_WIDE) : win_sum;
        win_idx  = win_wrap[PTR_W-1:0];
        next_ptr = (win_idx == LAST_IDX) ? '0 : (win_idx + 1'b1);
        win_drop = (rd_arr[win_idx] == '0) && !alu_error[win_idx];
    end

    // Next-state logic: flush first, then grant/capture, then plain drain.
    always_comb begin
        state_d      = state_q;
        res_d        = res_q;
        rd_d         = rd_q;
        err_d        = err_q;
        src_d        = src_q;
        rr_ptr_d     = rr_ptr_q;
        stale_mask_d = '0;
        alu_clear    = '0;
        if (rst_n) begin
            if (flush) begin
                alu_clear    = alu_valid;
                stale_mask_d = alu_valid;
                state_d      = ST_EMPTY;
            end else if (can_accept && found) begin
                alu_clear[win_idx]    = 1'b1;
                stale_mask_d[win_idx] = 1'b1;
                rr_ptr_d              = next_ptr;
                if (win_drop) begin
                    // Consumed without writeback; any entry present is draining now.
                    state_d = ST_EMPTY;
                end else begin
                    state_d = ST_FULL;
                    res_d   = res_arr[win_idx];
                    rd_d    = rd_arr[win_idx];
                    err_d   = alu_error[win_idx];
                    src_d   = win_idx;
                end
            end else if (wb_valid && wb_ready) begin
                state_d = ST_EMPTY;
            end
        end
    end

    // Writeback register, round-robin pointer and stale-valid mask.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_EMPTY;
            res_q        <= '0;
            rd_q         <= '0;
            err_q        <= 1'b0;
            src_q        <= '0;
            rr_ptr_q     <= '0;
            stale_mask_q <= '0;
        end else begin
            state_q      <= state_d;
            res_q        <= res_d;
            rd_q         <= rd_d;
            err_q        <= err_d;
            src_q        <= src_d;
            rr_ptr_q     <= rr_ptr_d;
            stale_mask_q <= stale_mask_d;
        end
    end

endmodule
